// File: rtl/ps2_key_scanner_pkg.sv
// Shared types and constants for the PS/2 key scanner: prefix FSM states,
// prefix byte values and the tracked-key lookup table.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_e;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam int KEY_TABLE_LEN = 17;

  // Entry is {present, ext, code}; indices past the table report absent.
  function automatic logic [9:0] key_entry(input int idx);
    case (idx)
      0:       key_entry = {1'b1, 1'b1, 8'h75};
      1:       key_entry = {1'b1, 1'b1, 8'h72};
      2:       key_entry = {1'b1, 1'b1, 8'h6B};
      3:       key_entry = {1'b1, 1'b1, 8'h74};
      4:       key_entry = {1'b1, 1'b0, 8'h1D};
      5:       key_entry = {1'b1, 1'b0, 8'h1B};
      6:       key_entry = {1'b1, 1'b0, 8'h1C};
      7:       key_entry = {1'b1, 1'b0, 8'h23};
      8:       key_entry = {1'b1, 1'b0, 8'h35};
      9:       key_entry = {1'b1, 1'b0, 8'h33};
      10:      key_entry = {1'b1, 1'b0, 8'h34};
      11:      key_entry = {1'b1, 1'b0, 8'h3B};
      12:      key_entry = {1'b1, 1'b0, 8'h4D};
      13:      key_entry = {1'b1, 1'b0, 8'h4C};
      14:      key_entry = {1'b1, 1'b0, 8'h4B};
      15:      key_entry = {1'b1, 1'b0, 8'h52};
      16:      key_entry = {1'b1, 1'b0, 8'h29};
      default: key_entry = 10'h000;
    endcase
  endfunction

  function automatic logic key_match(input int idx, input logic ext, input logic [7:0] code);
    logic [9:0] ent;
    ent = key_entry(idx);
    return ent[9] && (ent[8:0] == {ext, code});
  endfunction

endpackage

// File: rtl/ps2_key_scanner_if.sv
// Decoded-event handshake between the scanner (master) and its consumer (slave).
interface ps2_key_scanner_if;
  logic       EVT_READY;
  logic       EVT_VALID;
  logic [7:0] EVT_CODE;
  logic       EVT_EXT;
  logic       EVT_BREAK;

  modport master (output EVT_VALID, EVT_CODE, EVT_EXT, EVT_BREAK, input EVT_READY);
  modport slave  (input EVT_VALID, EVT_CODE, EVT_EXT, EVT_BREAK, output EVT_READY);
endinterface

// File: rtl/ps2_event_fifo.sv
// Small synchronous event FIFO; a push into a full FIFO is dropped unless a pop
// happens in the same cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full, do_pop, do_push;

  always_comb begin
    full    = (cnt_q == DEPTH_CNT);
    valid   = (cnt_q != '0);
    do_pop  = valid && pop_ready;
    do_push = push && (!full || do_pop);
    drop    = push && !do_push;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign head = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_key_scanner.sv
// PS/2 keyboard receiver: oversampled frame capture, E0/F0 prefix decoding,
// event FIFO and a held-key bitmap for a fixed set of game keys.
module ps2_key_scanner
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 250,
  parameter int TIMEOUT    = 4000,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_KEYS   = 17
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                PS2_KBCLK,
  input  logic                PS2_KBDAT,
  ps2_key_scanner_if.master   evt,
  output logic [NUM_KEYS-1:0] KEY_DOWN,
  output logic                FRAME_ERR,
  output logic                OVERFLOW
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          kbclk_s1_q, kbclk_q, kbdat_s1_q, kbdat_q;
  logic [DW-1:0] div_q, div_d;
  logic          prev_clk_q, prev_clk_d;
  logic [10:0]   shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic          frame_err_q, frame_err_d;
  prefix_state_e state_q, state_d;
  logic [NUM_KEYS-1:0] key_q, key_d;
  logic          overflow_q, overflow_d;

  logic          tick, fall, frame_done, frame_ok, accept;
  logic [7:0]    rx_byte;
  logic          evt_fire, evt_ext, evt_brk;
  logic          fifo_valid, fifo_drop;
  logic [9:0]    fifo_head;

  always_comb begin
    tick       = (div_q == DW'(CLK_DIV - 1));
    div_d      = tick ? '0 : div_q + DW'(1);
    prev_clk_d = tick ? kbclk_q : prev_clk_q;
    fall       = tick && prev_clk_q && !kbclk_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    to_d       = to_q;
    frame_done = 1'b0;
    if (fall) begin
      shift_d = {kbdat_q, shift_q[10:1]};
      to_d    = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d  = '0;
        frame_done = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (tick && bit_cnt_q != '0) begin
      // Stalled partial frame: drop it silently so the next start bit realigns.
      if (to_q == TW'(TIMEOUT - 1)) begin
        bit_cnt_d = '0;
        to_d      = '0;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
    frame_ok    = !shift_d[0] && shift_d[10] && (^shift_d[9:1]);
    accept      = frame_done && frame_ok;
    frame_err_d = frame_done && !frame_ok;
    rx_byte     = shift_d[8:1];
  end

  always_comb begin
    state_d  = state_q;
    evt_fire = 1'b0;
    evt_ext  = 1'b0;
    evt_brk  = 1'b0;
    if (frame_err_d) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == CODE_E0)      state_d = ST_EXT;
          else if (rx_byte == CODE_F0) state_d = ST_BRK;
          else                         evt_fire = 1'b1;
        end
        ST_EXT: begin
          if (rx_byte == CODE_F0) begin
            state_d = ST_EXT_BRK;
          end else begin
            evt_fire = 1'b1;
            evt_ext  = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          evt_fire = 1'b1;
          evt_brk  = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          evt_fire = 1'b1;
          evt_ext  = 1'b1;
          evt_brk  = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    key_d = key_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (evt_fire && key_match(i, evt_ext, rx_byte)) key_d[i] = !evt_brk;
    end
    overflow_d = overflow_q | fifo_drop;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      kbclk_s1_q  <= 1'b0;
      kbclk_q     <= 1'b0;
      kbdat_s1_q  <= 1'b0;
      kbdat_q     <= 1'b0;
      div_q       <= '0;
      prev_clk_q  <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      to_q        <= '0;
      frame_err_q <= 1'b0;
      state_q     <= ST_IDLE;
      key_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      kbclk_s1_q  <= PS2_KBCLK;
      kbclk_q     <= kbclk_s1_q;
      kbdat_s1_q  <= PS2_KBDAT;
      kbdat_q     <= kbdat_s1_q;
      div_q       <= div_d;
      prev_clk_q  <= prev_clk_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      to_q        <= to_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      key_q       <= key_d;
      overflow_q  <= overflow_d;
    end
  end

  ps2_event_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLOCK_50),
    .rst       (reset),
    .push      (evt_fire),
    .push_data ({evt_brk, evt_ext, rx_byte}),
    .pop_ready (evt.EVT_READY),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .drop      (fifo_drop)
  );

  assign evt.EVT_VALID = fifo_valid;
  assign evt.EVT_CODE  = fifo_head[7:0];
  assign evt.EVT_EXT   = fifo_head[8];
  assign evt.EVT_BREAK = fifo_head[9];
  assign KEY_DOWN      = key_q;
  assign FRAME_ERR     = frame_err_q;
  assign OVERFLOW      = overflow_q;

endmodule

// File: doc/ps2_key_scanner.md
PS2_KEY_SCANNER -- requirements
Module: ps2_key_scanner

Interface
REQ-001 The module SHALL provide parameter CLK_DIV, default 250, giving the number of CLOCK_50 cycles per sample tick.
REQ-002 The module SHALL provide parameter TIMEOUT, default 4000, giving the number of idle sample ticks before a partial frame is discarded.
REQ-003 The module SHALL provide parameter FIFO_DEPTH, default 4, a power of two no smaller than 2, giving the event FIFO depth.
REQ-004 The module SHALL provide parameter NUM_KEYS, default 17, no larger than 32, giving the number of tracked keys.
REQ-005 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-006 Port list (name, direction, width, meaning):
- CLOCK_50  in  1  board clock.
- reset  in  1  asynchronous, active-high.
- PS2_KBCLK  in  1  keyboard clock, asynchronous.
- PS2_KBDAT  in  1  keyboard data, asynchronous.
- EVT_READY  in  1  consumer accepts the head event.
- EVT_VALID  out  1  FIFO non-empty.
- EVT_CODE  out  8  scan code of the head event.
- EVT_EXT  out  1  head event had an E0 prefix.
- EVT_BREAK  out  1  head event had an F0 prefix (key release).
- KEY_DOWN  out  NUM_KEYS  held-key bitmap.
- FRAME_ERR  out  1  one-cycle pulse on a rejected frame.
- OVERFLOW  out  1  sticky; an event was dropped.

Function
REQ-007 PS2_KBCLK and PS2_KBDAT SHALL each pass through a 2-flop synchroniser before any use.
REQ-008 A sample tick SHALL pulse for one cycle every CLK_DIV cycles, from a counter running 0..CLK_DIV-1.
REQ-009 On a tick where the synchronised clock is 0 and was 1 on the previous tick, the module SHALL shift in the data bit LSB-first and increment the bit count.
REQ-010 When the bit count reaches 11, the frame SHALL be checked (start=0, stop=1, odd parity over data+parity) and the bit count cleared.
REQ-011 A failed check SHALL pulse FRAME_ERR for one cycle, return the prefix FSM to IDLE and produce no event.
REQ-012 While 0 < bit count < 11, after TIMEOUT ticks with no falling edge the bit count SHALL clear with no FRAME_ERR.
REQ-013 Prefix FSM states and transitions on each valid byte:
- IDLE: E0 -> EXT; F0 -> BRK; other -> event(ext=0, brk=0), stay IDLE.
- EXT: F0 -> EXT_BRK; other -> event(1,0), then IDLE.
- BRK: any byte -> event(0,1), then IDLE.
- EXT_BRK: any byte -> event(1,1), then IDLE.
REQ-014 An event SHALL be pushed into the FIFO in the same cycle as frame acceptance; EVT_VALID rises on the next cycle if the FIFO was empty.
REQ-015 A pop SHALL occur in any cycle where EVT_VALID and EVT_READY are both 1.
REQ-016 EVT_CODE, EVT_EXT and EVT_BREAK SHALL hold the head entry stable while EVT_VALID=1 and EVT_READY=0.
REQ-017 A push into a full FIFO SHALL be dropped and SHALL set OVERFLOW; a simultaneous pop and push when full SHALL both succeed.
REQ-018 Read and write pointers SHALL wrap modulo FIFO_DEPTH; a fill counter of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
REQ-019 An event whose {ext, code} matches key-table entry i SHALL set KEY_DOWN[i] (make) or clear it (break) in the same cycle as the push, regardless of FIFO space.
REQ-020 An event that does not match any table entry SHALL leave KEY_DOWN unchanged.

Reset
REQ-021 On reset assertion, all outputs SHALL go to 0 immediately: EVT_VALID, EVT_CODE, EVT_EXT, EVT_BREAK, KEY_DOWN, FRAME_ERR, OVERFLOW.
REQ-022 On reset assertion, the FIFO SHALL empty, the FSM SHALL go to IDLE, and the bit count, divider and timeout SHALL clear.
REQ-023 A frame in progress when reset is asserted SHALL be discarded.

Structure
REQ-024 Package ps2_pkg SHALL hold the FSM state type, the E0/F0 constants, and the NUM_KEYS key table {ext, code}.
REQ-025 Key table contents, index: {ext, code}:
- 0: {1,75}, 1: {1,72}, 2: {1,6B}, 3: {1,74} (arrow up, down, left, right).
- 4: {0,1D}, 5: {0,1B}, 6: {0,1C}, 7: {0,23} (W, S, A, D).
- 8: {0,35}, 9: {0,33}, 10: {0,34}, 11: {0,3B} (Y, H, G, J).
- 12: {0,4D}, 13: {0,4C}, 14: {0,4B}, 15: {0,52} (P, ;, L, ').
- 16: {0,29} (space).
REQ-026 The event FIFO SHALL be a sub-module named ps2_event_fifo, parametrised by width (10) and depth.

Verification
REQ-027 The bench SHALL cover these scenarios:
- Frame 1D with good parity -> EVT_VALID, CODE=1D, EXT=0, BREAK=0; KEY_DOWN[4]=1.
- Frames E0,F0,75 after E0,75 -> two events, the second with EXT=1, BREAK=1; KEY_DOWN[0] returns to 0.
- Frame 29 with bad parity -> FRAME_ERR pulse, no event, KEY_DOWN unchanged.
- 5 data bits then silence for TIMEOUT+1 ticks, then a good 1C frame -> single event CODE=1C.
- EVT_READY=0 with FIFO_DEPTH+1 frames -> FIFO_DEPTH events retained in order, OVERFLOW=1.
- reset asserted mid-frame and with the FIFO full -> all outputs 0 in the same cycle; the next good frame decodes correctly.
